btn_debounce: RTL and testbench

Upstream conditioning stage for the board push-button on the 25 MHz fabric clock. It synchronises the raw pad input, rejects contact bounce with a stable-time counter, and emits a clean level plus single-cycle press, release and long-press events. The LED/servo sequencer consumes `press_pulse` as its start request and `btn_level` as its hold/release qualifier, replacing direct use of the raw pad.

---
 rtl/btn_debounce.sv | 125 ++++++++++++
 tb/tb_btn_debounce.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stable-time debounce FSM, press/release/long-press strobes.
// Optional long-press detector enabled by defining BTN_LONG_PRESS_EN.
module btn_debounce #(
  parameter int unsigned DB_CYCLES   = 500_000,
  parameter int unsigned LONG_CYCLES = 25_000_000,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             s;
  logic             pad_active;

  assign pad_active = btn_raw ^ ACTIVE_LOW;

  // Synchroniser plus debounce FSM; any opposite sample in a WAIT state aborts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= 1'b0;
      s             <= 1'b0;
      state         <= RELEASED;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1         <= pad_active;
      s             <= sync1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      unique case (state)
        RELEASED: begin
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= RELEASED;
          end else if (cnt == CNT_LAST) begin
            state       <= PRESSED;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            state         <= RELEASED;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned LCNT_W = $clog2(LONG_CYCLES);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_CYCLES - 1);
  localparam logic [LCNT_W-1:0] LCNT_PRE  = LCNT_W'(LONG_CYCLES - 2);

  logic [LCNT_W-1:0] lcnt;
  logic              press_fire_c;
  logic              release_fire_c;
  logic              hold_c;

  assign press_fire_c   = (state == PRESS_WAIT) && s && (cnt == CNT_LAST);
  assign release_fire_c = (state == RELEASE_WAIT) && !s && (cnt == CNT_LAST);
  // Hold time keeps running through release bounce, but stops on the accepted release edge
  // so long_press can never share a cycle with (or follow) release_pulse.
  assign hold_c = (state == PRESSED) || ((state == RELEASE_WAIT) && !release_fire_c);

  // Saturating hold counter, cleared on the accepted press.
  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt       <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (press_fire_c) begin
        lcnt <= '0;
      end else if (hold_c && (lcnt != LCNT_LAST)) begin
        lcnt       <= lcnt + LCNT_W'(1);
        long_press <= (lcnt == LCNT_PRE);
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (DB_CYCLES=4, LONG_CYCLES=20); a second instance runs ACTIVE_LOW=1 on the inverted pad.
module tb_btn_debounce;

  localparam int unsigned DB   = 4;
  localparam int unsigned LONG = 20;
`ifdef BTN_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       raw;
  logic       raw_al;
  logic [1:0] lvl_v;
  logic [1:0] pp_v;
  logic [1:0] rp_v;
  logic [1:0] lp_v;

  assign raw_al = ~raw;

  btn_debounce #(.DB_CYCLES(DB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .btn_raw(raw),
    .btn_level(lvl_v[0]), .press_pulse(pp_v[0]), .release_pulse(rp_v[0]), .long_press(lp_v[0])
  );

  btn_debounce #(.DB_CYCLES(DB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .btn_raw(raw_al),
    .btn_level(lvl_v[1]), .press_pulse(pp_v[1]), .release_pulse(rp_v[1]), .long_press(lp_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc;
  int pc[2], rc[2], lc[2], pat[2], plast[2], rat[2], lat[2], lvln[2], multi[2], rviol[2];

  // One clock edge; outputs sampled 1 time unit later and folded into per-instance statistics.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (pp_v[i]) begin
        pc[i]++;
        if (pat[i] == 0) pat[i] = cyc;
        plast[i] = cyc;
      end
      if (rp_v[i]) begin
        rc[i]++;
        if (rat[i] == 0) rat[i] = cyc;
      end
      if (lp_v[i]) begin
        lc[i]++;
        if (lat[i] == 0) lat[i] = cyc;
      end
      if (lvl_v[i]) lvln[i]++;
      if ((int'(pp_v[i]) + int'(rp_v[i]) + int'(lp_v[i])) > 1) multi[i]++;
      if (rst && (lvl_v[i] || pp_v[i] || rp_v[i] || lp_v[i])) rviol[i]++;
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // Reset both instances, then restart edge numbering: edge 1 is the first edge with rst low.
  task automatic begin_scn();
    raw = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      pc[i] = 0; rc[i] = 0; lc[i] = 0; pat[i] = 0; plast[i] = 0;
      rat[i] = 0; lat[i] = 0; lvln[i] = 0; multi[i] = 0; rviol[i] = 0;
    end
  endtask

  task automatic test_reset();
    raw = 1'b0;
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (lvl_v !== 2'b00) begin n_fail++; $display("FAIL reset_level: got %b expected 00", lvl_v); end
    n_cmp++; if (pp_v !== 2'b00) begin n_fail++; $display("FAIL reset_press: got %b expected 00", pp_v); end
    n_cmp++; if (rp_v !== 2'b00) begin n_fail++; $display("FAIL reset_release: got %b expected 00", rp_v); end
    n_cmp++; if (lp_v !== 2'b00) begin n_fail++; $display("FAIL reset_long: got %b expected 00", lp_v); end
  endtask

  // Raw set just after edge 10 -> first sampled at 11 -> press at 11+2+DB = 17; release likewise at 27.
  task automatic test_clean_press();
    begin_scn();
    run_to(10); raw = 1'b1;
    run_to(20); raw = 1'b0;
    run_to(40);
    n_cmp++; if (pc[0] !== 1)  begin n_fail++; $display("FAIL clean_press_count: got %0d expected 1", pc[0]); end
    n_cmp++; if (pat[0] !== 17) begin n_fail++; $display("FAIL clean_press_edge: got %0d expected 17", pat[0]); end
    n_cmp++; if (lvln[0] !== 10) begin n_fail++; $display("FAIL clean_level_cycles: got %0d expected 10", lvln[0]); end
    n_cmp++; if (rc[0] !== 1)  begin n_fail++; $display("FAIL clean_release_count: got %0d expected 1", rc[0]); end
    n_cmp++; if (rat[0] !== 27) begin n_fail++; $display("FAIL clean_release_edge: got %0d expected 27", rat[0]); end
    n_cmp++; if (lc[0] !== 0)  begin n_fail++; $display("FAIL clean_long_count: got %0d expected 0", lc[0]); end
  endtask

  // Last 0 sampled at edge 15, stable 1 from edge 16 -> press at 16+2+DB = 22.
  task automatic test_bounce();
    logic [9:0] bp;
    bp = 10'b1111101101;
    begin_scn();
    run_to(10);
    for (int i = 0; i < 10; i++) begin
      raw = bp[i];
      step();
    end
    run_to(30); raw = 1'b0;
    run_to(50);
    n_cmp++; if (pc[0] !== 1)  begin n_fail++; $display("FAIL bounce_press_count: got %0d expected 1", pc[0]); end
    n_cmp++; if (pat[0] !== 22) begin n_fail++; $display("FAIL bounce_press_edge: got %0d expected 22", pat[0]); end
    n_cmp++; if (rc[0] !== 1)  begin n_fail++; $display("FAIL bounce_release_count: got %0d expected 1", rc[0]); end
    n_cmp++; if (rat[0] !== 37) begin n_fail++; $display("FAIL bounce_release_edge: got %0d expected 37", rat[0]); end
  endtask

  task automatic test_glitch();
    begin_scn();
    for (int w = 1; w <= 3; w++) begin
      raw = 1'b1;
      repeat (w) step();
      raw = 1'b0;
      repeat (10) step();
    end
    n_cmp++; if ((pc[0] + rc[0] + lc[0] + lvln[0]) !== 0) begin
      n_fail++; $display("FAIL glitch_outputs: got %0d active samples expected 0", pc[0] + rc[0] + lc[0] + lvln[0]);
    end
    n_cmp++; if ((pc[1] + rc[1] + lc[1] + lvln[1]) !== 0) begin
      n_fail++; $display("FAIL glitch_outputs_al: got %0d active samples expected 0", pc[1] + rc[1] + lc[1] + lvln[1]);
    end
  endtask

  // A 4-sample pulse aborts one edge short of acceptance; 5 samples is the shortest accepted press.
  task automatic test_threshold();
    begin_scn();
    run_to(10); raw = 1'b1;
    repeat (4) step();
    raw = 1'b0;
    run_to(30);
    n_cmp++; if (pc[0] !== 0) begin n_fail++; $display("FAIL thresh4_press_count: got %0d expected 0", pc[0]); end
    begin_scn();
    run_to(10); raw = 1'b1;
    repeat (5) step();
    raw = 1'b0;
    run_to(35);
    n_cmp++; if (pc[0] !== 1)  begin n_fail++; $display("FAIL thresh5_press_count: got %0d expected 1", pc[0]); end
    n_cmp++; if (pat[0] !== 17) begin n_fail++; $display("FAIL thresh5_press_edge: got %0d expected 17", pat[0]); end
    n_cmp++; if (rat[0] !== 22) begin n_fail++; $display("FAIL thresh5_release_edge: got %0d expected 22", rat[0]); end
    n_cmp++; if (lvln[0] !== 5) begin n_fail++; $display("FAIL thresh5_level_cycles: got %0d expected 5", lvln[0]); end
  endtask

  // Press at 17, long press 19 edges later at 36, release at 57.
  task automatic test_long_press();
    int exp_lc;
    int exp_lat;
    exp_lc  = LP_EN ? 1 : 0;
    exp_lat = LP_EN ? 36 : 0;
    begin_scn();
    run_to(10); raw = 1'b1;
    run_to(50); raw = 1'b0;
    run_to(70);
    n_cmp++; if (pc[0] !== 1) begin n_fail++; $display("FAIL long_press_count: got %0d expected 1", pc[0]); end
    n_cmp++; if (lc[0] !== exp_lc) begin n_fail++; $display("FAIL long_count: got %0d expected %0d", lc[0], exp_lc); end
    n_cmp++; if (lat[0] !== exp_lat) begin n_fail++; $display("FAIL long_edge: got %0d expected %0d", lat[0], exp_lat); end
    n_cmp++; if (rc[0] !== 1)  begin n_fail++; $display("FAIL long_release_count: got %0d expected 1", rc[0]); end
    n_cmp++; if (rat[0] !== 57) begin n_fail++; $display("FAIL long_release_edge: got %0d expected 57", rat[0]); end
    n_cmp++; if (multi[0] !== 0) begin n_fail++; $display("FAIL long_one_pulse_per_cycle: got %0d expected 0", multi[0]); end
  endtask

  // Synchroniser restarts from 0 after reset, so a held button is re-accepted at (first low-rst edge)+2+DB.
  task automatic test_reset_mid();
    begin_scn();
    run_to(10); raw = 1'b1;
    run_to(14); rst = 1'b1;
    run_to(17); rst = 1'b0;
    run_to(28); rst = 1'b1;
    run_to(30); rst = 1'b0;
    run_to(50);
    n_cmp++; if (rviol[0] !== 0) begin n_fail++; $display("FAIL rst_outputs_zero: got %0d active samples expected 0", rviol[0]); end
    n_cmp++; if (pc[0] !== 2)  begin n_fail++; $display("FAIL rst_press_count: got %0d expected 2", pc[0]); end
    n_cmp++; if (pat[0] !== 24) begin n_fail++; $display("FAIL rst_first_press_edge: got %0d expected 24", pat[0]); end
    n_cmp++; if (plast[0] !== 37) begin n_fail++; $display("FAIL rst_second_press_edge: got %0d expected 37", plast[0]); end
    n_cmp++; if (rc[0] !== 0)  begin n_fail++; $display("FAIL rst_release_count: got %0d expected 0", rc[0]); end
    n_cmp++; if (lc[0] !== 0)  begin n_fail++; $display("FAIL rst_long_count: got %0d expected 0", lc[0]); end
  endtask

  // Pad idles high and is pressed low on the ACTIVE_LOW instance; same edges as the clean press.
  task automatic test_active_low();
    begin_scn();
    run_to(10); raw = 1'b1;
    run_to(20); raw = 1'b0;
    run_to(40);
    n_cmp++; if (pc[1] !== 1)  begin n_fail++; $display("FAIL al_press_count: got %0d expected 1", pc[1]); end
    n_cmp++; if (pat[1] !== 17) begin n_fail++; $display("FAIL al_press_edge: got %0d expected 17", pat[1]); end
    n_cmp++; if (lvln[1] !== 10) begin n_fail++; $display("FAIL al_level_cycles: got %0d expected 10", lvln[1]); end
    n_cmp++; if (rc[1] !== 1)  begin n_fail++; $display("FAIL al_release_count: got %0d expected 1", rc[1]); end
    n_cmp++; if (rat[1] !== 27) begin n_fail++; $display("FAIL al_release_edge: got %0d expected 27", rat[1]); end
    n_cmp++; if (lc[1] !== 0)  begin n_fail++; $display("FAIL al_long_count: got %0d expected 0", lc[1]); end
  endtask

  initial begin
    rst = 1'b1;
    raw = 1'b0;
    cyc = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_threshold();
    test_long_press();
    test_reset_mid();
    test_active_low();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
